// File: rtl/intra_ref_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | intra_ref_align - drives yPos to the angular shift table and aligns a     |
// | latched 7-sample reference window into 4-lane rows.        Rev 1.0       |
// +--------------------------------------------------------------------------+
module intra_ref_align #(
    parameter int BIT_DEPTH = 8,
    parameter int ROWS      = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4:0]             ang,
    input  logic [7*BIT_DEPTH-1:0] ref_win,
    output logic [4:0]             lut_ang,
    output logic [2:0]             lut_ypos,
    input  logic [11:0]            lut_move,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2:0]             out_row,
    output logic [4*BIT_DEPTH-1:0] out_samples,
    output logic                   busy,
    output logic                   done,
    output logic                   move_err
);
    localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [4:0]                ang_q, ang_d;
    logic [6:0][BIT_DEPTH-1:0] win_q, win_d;
    logic [2:0]                row_q, row_d;
    logic                      valid_q, valid_d;
    logic [2:0]                orow_q, orow_d;
    logic [3:0][BIT_DEPTH-1:0] samp_q, samp_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;
    logic                      load;
    logic [3:0][BIT_DEPTH-1:0] aligned;
    logic [3:0]                lane_over;

    // Moves of 4..7 clamp to 3, so lane + move never exceeds window index 6.
    generate
        for (genvar k = 0; k < 4; k++) begin : g_lane
            logic [2:0] mv;
            logic [2:0] mv_clamped;
            logic [2:0] idx;
            assign mv           = lut_move[3*k +: 3];
            assign lane_over[k] = mv[2];
            assign mv_clamped   = mv[2] ? 3'd3 : mv;
            assign idx          = 3'(k) + mv_clamped;
            assign aligned[k]   = win_q[idx];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        ang_d   = ang_q;
        win_d   = win_q;
        row_d   = row_q;
        valid_d = valid_q;
        orow_d  = orow_q;
        samp_d  = samp_q;
        done_d  = 1'b0;
        err_d   = err_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ang_d   = ang;
                    win_d   = ref_win;
                    err_d   = 1'b0;
                    row_d   = 3'd0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                load = !valid_q || out_ready;
                if (load) begin
                    samp_d  = aligned;
                    orow_d  = row_q;
                    valid_d = 1'b1;
                    if (|lane_over) err_d = 1'b1;
                    if (row_q == LAST_ROW) state_d = S_DRAIN;
                    else                   row_d   = row_q + 3'd1;
                end
            end
            S_DRAIN: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ang_q   <= '0;
            win_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            orow_q  <= '0;
            samp_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ang_q   <= ang_d;
            win_q   <= win_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            orow_q  <= orow_d;
            samp_q  <= samp_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // lut_ypos reads 0 outside a strip so an async reset zeroes it at once.
    assign lut_ang     = ang_q;
    assign lut_ypos    = (state_q == S_IDLE) ? 3'd0 : row_q;
    assign out_valid   = valid_q;
    assign out_row     = orow_q;
    assign out_samples = samp_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign move_err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_intra_ref_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_intra_ref_align - strip-level reference model and per-cycle checks.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_intra_ref_align;
    localparam int BD   = 8;
    localparam int ROWS = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            out_ready = 1'b0;
    logic [4:0]      ang = '0;
    logic [7*BD-1:0] ref_win = '0;
    logic [4:0]      lut_ang;
    logic [2:0]      lut_ypos;
    logic [11:0]     lut_move;
    logic            out_valid;
    logic [2:0]      out_row;
    logic [4*BD-1:0] out_samples;
    logic            busy, done, move_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit clamp_mode = 1'b0;

    intra_ref_align #(.BIT_DEPTH(BD), .ROWS(ROWS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ang(ang), .ref_win(ref_win),
        .lut_ang(lut_ang), .lut_ypos(lut_ypos), .lut_move(lut_move),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_samples(out_samples), .busy(busy), .done(done), .move_err(move_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Table stand-in: fixed rows for angles 16 and 8, a hash (with
    // out-of-range fields) for every other angle.
    function automatic logic [11:0] lut_fn(input logic [4:0] a, input logic [2:0] y, input bit cm);
        logic [11:0] m;
        if (cm) return (y == 3'd2) ? 12'hFFF : 12'h000;
        if (a == 5'd16) return 12'h053;
        if (a == 5'd8) return 12'h000;
        m = '0;
        for (int k = 0; k < 4; k++) m[3*k +: 3] = 3'((int'(a) * 3 + int'(y) * 5 + k * 7) % 8);
        return m;
    endfunction

    always_comb lut_move = lut_fn(lut_ang, lut_ypos, clamp_mode);

    function automatic int lane_move(input logic [11:0] mv, input int k);
        int m;
        m = int'(mv[3*k +: 3]);
        return (m > 3) ? 3 : m;
    endfunction

    function automatic bit any_over(input logic [11:0] mv);
        for (int k = 0; k < 4; k++) if (int'(mv[3*k +: 3]) > 3) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [4*BD-1:0] exp_row(input logic [7*BD-1:0] w, input logic [11:0] mv);
        logic [4*BD-1:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) r[BD*k +: BD] = w[BD*(k + lane_move(mv, k)) +: BD];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, expv, cyc);
        end
    endtask

    // Model: a strip is "rows loaded" vs "rows accepted" counters.
    bit              m_active = 1'b0, m_done = 1'b0, m_err = 1'b0;
    int              m_ld = 0, m_acc = 0;
    logic [4:0]      m_ang = '0;
    logic [7*BD-1:0] m_win = '0;

    always @(negedge clk) begin
        bit v, hs, ld;
        if (!rst_n) begin
            m_active = 1'b0; m_done = 1'b0; m_err = 1'b0;
            m_ld = 0; m_acc = 0; m_ang = '0; m_win = '0;
            chk("rst_valid", 64'(out_valid), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_done", 64'(done), 64'd0);
            chk("rst_ypos", 64'(lut_ypos), 64'd0);
            chk("rst_samples", 64'(out_samples), 64'd0);
        end else begin
            v = (m_ld > m_acc);
            chk("valid", 64'(out_valid), 64'(v));
            chk("busy", 64'(busy), 64'(m_active));
            chk("done", 64'(done), 64'(m_done));
            chk("move_err", 64'(move_err), 64'(m_err));
            chk("lut_ang", 64'(lut_ang), 64'(m_ang));
            chk("lut_ypos", 64'(lut_ypos), m_active ? 64'((m_ld < ROWS) ? m_ld : ROWS - 1) : 64'd0);
            if (v) begin
                chk("out_row", 64'(out_row), 64'(m_acc));
                chk("out_samples", 64'(out_samples),
                    64'(exp_row(m_win, lut_fn(m_ang, 3'(m_acc), clamp_mode))));
            end
            m_done = 1'b0;
            if (!m_active) begin
                if (start) begin
                    m_active = 1'b1; m_ld = 0; m_acc = 0;
                    m_ang = ang; m_win = ref_win; m_err = 1'b0;
                end
            end else begin
                hs = v && out_ready;
                ld = (m_ld < ROWS) && (!v || out_ready);
                if (ld) begin
                    if (any_over(lut_fn(m_ang, 3'(m_ld), clamp_mode))) m_err = 1'b1;
                    m_ld++;
                end
                if (hs) begin
                    m_acc++;
                    if (m_acc == ROWS) begin
                        m_active = 1'b0;
                        m_done   = 1'b1;
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_strip(input logic [4:0] a, input logic [7*BD-1:0] w, output int t0);
        ang = a; ref_win = w; start = 1'b1; t0 = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_row(input int r, output logic [4*BD-1:0] s, output int when);
        s = '0; when = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid && out_ready && int'(out_row) == r) begin
                s = out_samples; when = cyc;
                return;
            end
        end
        chk("row_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_done(output int when);
        when = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                when = cyc;
                return;
            end
        end
        chk("done_timeout", 64'd0, 64'd1);
    endtask

    localparam logic [7*BD-1:0] W = {8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};

    initial begin
        int t0, when;
        logic [4*BD-1:0] s;
        bit seen;

        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        out_ready = 1'b1;

        // Vertical row: every lane picks win[3].
        start_strip(5'd16, W, t0);
        wait_row(0, s, when);
        chk("vert_row0", 64'(s), 64'h28282828);
        chk("vert_latency", 64'(when), 64'(t0 + 2));
        wait_done(when);
        chk("vert_done_time", 64'(when), 64'(t0 + 10));
        tick();

        // Zero angle.
        start_strip(5'd8, W, t0);
        wait_row(0, s, when);
        chk("zero_row0", 64'(s), 64'h281E140A);
        wait_row(7, s, when);
        chk("zero_row7", 64'(s), 64'h281E140A);
        wait_done(when);
        tick();

        // Backpressure with ready pattern 1,0,0,1.
        start_strip(5'd16, W, t0);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            out_ready = (i % 4 == 0) || (i % 4 == 3);
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("bp_done_seen", 64'(seen), 64'd1);
        tick();
        out_ready = 1'b1;

        // Clamp on row 2, then a new start clears the sticky flag.
        clamp_mode = 1'b1;
        start_strip(5'd8, W, t0);
        wait_row(2, s, when);
        chk("clamp_row2", 64'(s), 64'h463C3228);
        wait_done(when);
        chk("clamp_err_sticky", 64'(move_err), 64'd1);
        tick();
        clamp_mode = 1'b0;
        start_strip(5'd8, W, t0);
        chk("err_cleared", 64'(move_err), 64'd0);
        wait_done(when);
        tick();

        // Asynchronous reset mid-strip.
        start_strip(5'd16, W, t0);
        wait_row(4, s, when);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_ypos", 64'(lut_ypos), 64'd0);
        @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        start_strip(5'd8, W, t0);
        wait_row(0, s, when);
        chk("restart_row0", 64'(s), 64'h281E140A);
        chk("restart_latency", 64'(when), 64'(t0 + 2));
        wait_done(when);
        tick();

        // Start held high through a strip.
        ang = 5'd16; ref_win = W; start = 1'b1; t0 = cyc;
        wait_done(when);
        chk("held_done_time", 64'(when), 64'(t0 + 10));
        tick();
        start = 1'b0;
        wait_row(0, s, when);
        chk("second_row0_time", 64'(when), 64'(t0 + 12));
        wait_done(when);
        tick();

        // Randomized strips: random angles/windows, ready, and spurious starts.
        for (int n = 0; n < 25; n++) begin
            start_strip(5'($urandom_range(0, 31)), 56'({$urandom, $urandom}), t0);
            for (int i = 0; i < 200; i++) begin
                ang       = 5'($urandom_range(0, 31));
                ref_win   = 56'({$urandom, $urandom});
                out_ready = ($urandom_range(0, 3) != 0);
                start     = ($urandom_range(0, 7) == 0);
                @(negedge clk);
                if (done) break;
                tick();
            end
            tick();
            start = 1'b0;
            out_ready = 1'b1;
            for (int i = 0; i < 40 && busy; i++) tick();
        end

        out_ready = 1'b1;
        start = 1'b0;
        repeat (20) tick();
        chk("final_idle", 64'(busy), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
